// File: rtl/pc_seq_unit_pkg.sv
// pc_pkg: shared constants for the PC sequencing unit.
//   Sel encodings, PC increment, RAS_Err bit indices and field widths.
package pc_pkg;

  localparam int unsigned SEL_W  = 2;
  localparam int unsigned OFF_W  = 16;
  localparam int unsigned ERR_W  = 2;

  localparam logic [SEL_W-1:0] SEL_SEQ    = 2'b00;
  localparam logic [SEL_W-1:0] SEL_BRANCH = 2'b01;
  localparam logic [SEL_W-1:0] SEL_JUMP   = 2'b10;
  localparam logic [SEL_W-1:0] SEL_RET    = 2'b11;

  localparam int unsigned PC_INC = 4;

  localparam int unsigned ERR_UNDER = 0;
  localparam int unsigned ERR_OVER  = 1;

endpackage

// File: rtl/pc_seq_unit_if.sv
// pc_seq_unit_if: control/fetch-side bundle of the PC sequencing unit.
//   master: control FSM side (drives PCWrite, Sel, Call, BranchOff, JumpTarget)
//   slave : pc_seq_unit side (drives PC_Out, RAS_Empty, RAS_Full, RAS_Err, Misalign)
interface pc_seq_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  import pc_pkg::*;

  logic                    PCWrite;
  logic [SEL_W-1:0]        Sel;
  logic                    Call;
  logic [OFF_W-1:0]        BranchOff;
  logic [ADDR_W-1:0]       JumpTarget;
  logic [ADDR_W-1:0]       PC_Out;
  logic                    RAS_Empty;
  logic                    RAS_Full;
  logic [ERR_W-1:0]        RAS_Err;
  logic                    Misalign;

  modport master (
    output PCWrite, Sel, Call, BranchOff, JumpTarget,
    input  PC_Out, RAS_Empty, RAS_Full, RAS_Err, Misalign
  );

  modport slave (
    input  PCWrite, Sel, Call, BranchOff, JumpTarget,
    output PC_Out, RAS_Empty, RAS_Full, RAS_Err, Misalign
  );

endinterface

// File: rtl/pc_seq_unit_ras.sv
// pc_ras: circular return-address stack with push, pop and replace.
//   CLK, Reset    : clock, synchronous active-high reset
//   en            : update enable (PCWrite); nothing changes when low
//   push, pop     : Call and Sel==RET; both together replace the top entry
//   wdata         : return address to push (PC+4)
//   top_c         : current top entry (combinational read of state)
//   empty, full   : registered status derived from the entry count
//   under_c/over_c: one-cycle error strobes for the update being applied
module pc_ras #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              en,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] top_c,
  output logic              empty,
  output logic              full,
  output logic              under_c,
  output logic              over_c
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] ent [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, wr_ptr_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_c;
  logic              is_empty_c, is_full_c;

  assign is_empty_c = (cnt_q == '0);
  assign is_full_c  = (cnt_q == DEPTH_C);
  assign top_c      = ent[ptr_q];

  // Stack update; pointer wraps naturally since RAS_DEPTH is a power of two
  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    wr_c     = 1'b0;
    wr_ptr_c = ptr_q;
    under_c  = 1'b0;
    over_c   = 1'b0;
    if (en) begin
      if (pop && is_empty_c) begin
        under_c = 1'b1;
        if (push) begin
          ptr_d    = ptr_q + PTR_W'(1);
          wr_c     = 1'b1;
          wr_ptr_c = ptr_q + PTR_W'(1);
          cnt_d    = CNT_W'(1);
        end
      end else if (pop && push) begin
        // Return and call together: top replaced in place
        wr_c     = 1'b1;
        wr_ptr_c = ptr_q;
      end else if (pop) begin
        ptr_d = ptr_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end else if (push) begin
        ptr_d    = ptr_q + PTR_W'(1);
        wr_c     = 1'b1;
        wr_ptr_c = ptr_q + PTR_W'(1);
        // When full, the new slot is the oldest entry; count saturates
        if (is_full_c) over_c = 1'b1;
        else           cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  // Pointer, count and status flags
  always_ff @(posedge CLK) begin
    if (Reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      empty <= (cnt_d == '0);
      full  <= (cnt_d == DEPTH_C);
    end
  end

  // Entry storage; contents are meaningless after reset so no reset here
  always_ff @(posedge CLK) begin
    if (wr_c) ent[wr_ptr_c] <= wdata;
  end

endmodule

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program counter with internal next-PC selection and RAS.
//   CLK, Reset : clock, synchronous active-high reset (wins over PCWrite)
//   bus        : pc_seq_unit_if.slave -- PCWrite, Sel, Call, BranchOff,
//                JumpTarget in; PC_Out, RAS_Empty, RAS_Full, RAS_Err, Misalign out
// Optional macro PC_ALIGN_CHECK_EN: a misaligned next PC loads TRAP_VEC and
// pulses Misalign; without it Misalign is constant 0.
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0]    RESET_VEC = '0,
  parameter logic [ADDR_W-1:0]    TRAP_VEC  = ADDR_W'(32'h80)
) (
  input  logic          CLK,
  input  logic          Reset,
  pc_seq_unit_if.slave  bus
);

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic [ADDR_W-1:0] pc_q, seq_c, br_off_c, sel_pc_c, pc_d, ras_top_c;
  logic [ERR_W-1:0]  err_q;
  logic              mis_q, mis_c;
  logic              ras_empty, ras_full, under_c, over_c;
  logic              ret_c;

  assign ret_c = (bus.Sel == SEL_RET);

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK     (CLK),
    .Reset   (Reset),
    .en      (bus.PCWrite),
    .push    (bus.Call),
    .pop     (ret_c),
    .wdata   (seq_c),
    .top_c   (ras_top_c),
    .empty   (ras_empty),
    .full    (ras_full),
    .under_c (under_c),
    .over_c  (over_c)
  );

  // Next-PC candidates; all sums wrap modulo 2^ADDR_W
  assign seq_c    = pc_q + ADDR_W'(PC_INC);
  assign br_off_c = {{(ADDR_W-OFF_W){bus.BranchOff[OFF_W-1]}}, bus.BranchOff} << 2;

  always_comb begin
    sel_pc_c = seq_c;
    case (bus.Sel)
      SEL_SEQ:    sel_pc_c = seq_c;
      SEL_BRANCH: sel_pc_c = seq_c + br_off_c;
      SEL_JUMP:   sel_pc_c = bus.JumpTarget;
      default:    sel_pc_c = under_c ? seq_c : ras_top_c;
    endcase
  end

  assign mis_c = ALIGN_CHK && (sel_pc_c[1:0] != 2'b00);
  assign pc_d  = mis_c ? TRAP_VEC : sel_pc_c;

  // PC, sticky RAS errors and misalign pulse
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_q  <= RESET_VEC;
      err_q <= '0;
      mis_q <= 1'b0;
    end else begin
      mis_q <= bus.PCWrite & mis_c;
      if (bus.PCWrite) pc_q <= pc_d;
      err_q[ERR_UNDER] <= err_q[ERR_UNDER] | under_c;
      err_q[ERR_OVER]  <= err_q[ERR_OVER]  | over_c;
    end
  end

  assign bus.PC_Out    = pc_q;
  assign bus.RAS_Empty = ras_empty;
  assign bus.RAS_Full  = ras_full;
  assign bus.RAS_Err   = err_q;
  assign bus.Misalign  = mis_q;

endmodule
